iter_mul: RTL
=============

Name: iter_mul

Overview:
- Sequential shift-and-add multiplier for MUL / UMULH.
- Consumes the two operands read from the register file (rd1, rd2).
- Returns its 64-bit result to the register file write port as wd3 / wa3 / we3.
- Sits beside the single-cycle ALU. The control unit raises start and stalls the PC while busy is high.

Parameters:
- N  64  operand width; also the number of RUN cycles (one multiplier bit per cycle).

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
- start  in  1  request a multiply; accepted only in IDLE.
- op_umulh  in  1  0 = MUL (low N bits of product), 1 = UMULH (high N bits of unsigned product).
- a  in  N  multiplicand (from rd1).
- b  in  N  multiplier (from rd2).
- dest  in  5  destination register index.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result is valid.
- wd3  out  N  result.
- wa3  out  5  captured dest.
- we3  out  1  write enable to register file; equals done, forced 0 when wa3 == 31.

Behaviour:
- Reset (reset == 0 at posedge):
  - state = IDLE; counter = 0; product accumulator = 0.
  - Outputs: busy = 0, done = 0, we3 = 0, wd3 = 0, wa3 = 0.
  - Reset overrides start and any in-flight operation.
- States:
  - IDLE -> RUN on start == 1. At that edge, capture a, b, dest and op_umulh into internal registers, clear the 2N-bit accumulator, and set counter = 0.
  - RUN, each edge:
    - If captured b bit[counter] == 1, add (a zero-extended to 2N bits, shifted left by counter) to the accumulator.
    - Addition is modulo 2^(2N); it can never overflow 2N bits for unsigned operands.
    - counter increments.
    - After the edge that processes bit N-1, go to DONE.
  - DONE, one cycle only:
    - done = 1.
    - wd3 = acc[N-1:0] if MUL, acc[2N-1:N] if UMULH.
    - we3 = (wa3 != 31).
    - Next edge -> IDLE.
- Latency: start sampled at edge E0; done high during the cycle after edge E0+N, i.e. N+1 cycles after acceptance (65 for N = 64).
- Operands are captured at acceptance. Later changes on a, b, dest or op_umulh are ignored until the next acceptance.
- start in RUN or DONE is ignored: no queueing, no restart. A start still high in IDLE after DONE is a new request.
- wd3 and wa3 hold their last values in IDLE; done and we3 are low outside DONE.
- XZR: dest == 31 runs the full operation and pulses done, but we3 stays 0.
- Reset mid-RUN aborts the operation: no done, no we3, and the accumulator is cleared.
- Counter width is clog2(N). The terminal test is counter == N-1 in RUN.

Decomposition:
- Shared package arith_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constants XZR_IDX = 5'd31, OP_MUL = 1'b0, OP_UMULH = 1'b1.
- No sub-module: datapath (accumulator, shift, add, counter) and FSM live in a single module.

Test Plan:
- a=3, b=5, MUL, dest=2 -> done exactly 65 cycles after start is accepted; wd3=15, wa3=2, we3=1 for one cycle; busy high for 65 cycles.
- a=2^63, b=4, UMULH, dest=7 -> wd3=2; same stimulus with MUL -> wd3=0.
- a=b=2^64-1: MUL -> wd3=1; UMULH -> wd3=2^64-2.
- dest=31, a=6, b=7 -> done pulses with wd3=42, we3 stays 0.
- start held high through RUN, and a/b changed to 0 mid-run -> result still uses the captured operands; exactly one done; a new acceptance occurs only after returning to IDLE.
- reset=0 asserted at cycle 30 of RUN, then released -> busy=0, done=0 and we3=0 immediately after the reset edge; no done until a fresh start; the next operation (9*9) yields 81.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: multiplier FSM states and register-file constants.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] XZR_IDX  = 5'd31;
  localparam logic       OP_MUL   = 1'b0;
  localparam logic       OP_UMULH = 1'b1;

endpackage

// File: rtl/iter_mul.sv
// Sequential shift-and-add multiplier for MUL / UMULH, one multiplier bit per cycle.
// Result goes straight to the register file write port (wd3 / wa3 / we3).
module iter_mul
  import arith_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_umulh,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   dest,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] wd3,
  output logic [4:0]   wa3,
  output logic         we3
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = 2 * N;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] addend;
  logic [AW-1:0] acc_sum;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          op_q;
  logic          last_bit;

  // Partial product for the current multiplier bit, folded into the accumulator.
  always_comb begin
    addend = '0;
    if (b_q[cnt]) begin
      addend = AW'(a_q) << cnt;
    end
    acc_sum  = acc + addend;
    last_bit = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MUL;
      busy  <= 1'b0;
      done  <= 1'b0;
      we3   <= 1'b0;
      wd3   <= '0;
      wa3   <= '0;
    end else begin
      done <= 1'b0;
      we3  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_umulh;
            wa3   <= dest;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          cnt <= cnt + CW'(1);
          // Result is registered on the edge that folds in the final bit.
          if (last_bit) begin
            state <= DONE;
            done  <= 1'b1;
            we3   <= (wa3 != XZR_IDX);
            wd3   <= (op_q == OP_UMULH) ? acc_sum[AW-1:N] : acc_sum[N-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
